// File: rtl/lock_pkg.sv
// Shared definitions for the digit lock controller.
//   state_t  : controller FSM states
//   SEG_*    : 7-segment status patterns, bit6=a .. bit0=g, active-high
//   cnt_w()  : bits needed to hold values 0..max_val (never less than 1)
package lock_pkg;

  typedef enum logic [2:0] {
    ENTRY    = 3'd0,
    CHECK    = 3'd1,
    UNLOCKED = 3'd2,
    LOCKOUT  = 3'd3,
    PROGRAM  = 3'd4
  } state_t;

  localparam logic [6:0] SEG_L    = 7'b0001110;
  localparam logic [6:0] SEG_U    = 7'b0111110;
  localparam logic [6:0] SEG_P    = 7'b1100111;
  localparam logic [6:0] SEG_DASH = 7'b0000001;

  function automatic int cnt_w(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/digit_collector.sv
// Digit collector: writes one digit per load into slot `count` of a shift
// buffer and advances `count`, wrapping to 0 after the last slot.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : empty buffer and zero count (wins over load)
//   load       : store digit this cycle
//   digit      : digit to store
//   data       : registered buffer, digit 0 in the LSBs
//   data_next  : buffer with the current digit inserted (valid when load=1)
//   count      : digits collected so far
//   full       : this load completes the code
module digit_collector
  import lock_pkg::*;
#(
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              load,
  input  logic [DIGIT_W-1:0]                digit,
  output logic [DIGIT_W*NUM_DIGITS-1:0]     data,
  output logic [DIGIT_W*NUM_DIGITS-1:0]     data_next,
  output logic [cnt_w(NUM_DIGITS)-1:0]      count,
  output logic                              full
);

  localparam int CW = cnt_w(NUM_DIGITS);

  always_comb begin
    data_next = data;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (count == CW'(i)) data_next[i*DIGIT_W +: DIGIT_W] = digit;
    end
  end

  assign full = load && (count == CW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= data_next;
      count <= full ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/digit_lock_ctrl.sv
// Multi-digit code lock controller.
//   clk, rst      : clock, synchronous active-high reset
//   digit_in      : entered digit
//   digit_valid   : digit_in is taken on every cycle this is high
//   clear         : abort current entry / programming sequence
//   lock_req      : relock while unlocked (also aborts programming)
//   set_mode      : start programming a new code while unlocked
//   unlocked      : lock open (also high during programming)
//   locked_out    : lockout in progress
//   alarm         : high for the whole lockout
//   fail_cnt      : consecutive wrong attempts, saturates at MAX_TRIES
//   entry_cnt     : digits collected in the current sequence
//   code_updated  : one-cycle pulse when a new code is stored
//   seven         : status glyph, bit6=a .. bit0=g
//
// Handshake: the input side has no back-pressure. Every cycle with
// digit_valid=1 is one digit; it is consumed in ENTRY and PROGRAM and
// silently dropped in every other state. All outputs are registered.
module digit_lock_ctrl
  import lock_pkg::*;
#(
  parameter int DIGIT_W        = 4,
  parameter int NUM_DIGITS     = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] RESET_CODE = 16'h0111
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W-1:0]            digit_in,
  input  logic                          digit_valid,
  input  logic                          clear,
  input  logic                          lock_req,
  input  logic                          set_mode,
  output logic                          unlocked,
  output logic                          locked_out,
  output logic                          alarm,
  output logic [cnt_w(MAX_TRIES)-1:0]   fail_cnt,
  output logic [cnt_w(NUM_DIGITS)-1:0]  entry_cnt,
  output logic                          code_updated,
  output logic [6:0]                    seven
);

  localparam int DW = DIGIT_W * NUM_DIGITS;
  localparam int FW = cnt_w(MAX_TRIES);
  localparam int LW = cnt_w(LOCKOUT_CYCLES);

  state_t          state;
  logic [DW-1:0]   code_q;
  logic [LW-1:0]   lock_cnt;

  logic            col_clear;
  logic            col_load;
  logic            col_full;
  logic [DW-1:0]   buf_data;
  logic [DW-1:0]   buf_next;

  // One collector serves both ENTRY and PROGRAM. In PROGRAM a lock_req
  // abort must also discard the partial sequence.
  assign col_clear = ((state == ENTRY)   && clear) ||
                     ((state == PROGRAM) && (clear || lock_req));
  assign col_load  = ((state == ENTRY) || (state == PROGRAM)) &&
                     digit_valid && !col_clear;

  digit_collector #(
    .DIGIT_W    (DIGIT_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_collector (
    .clk       (clk),
    .rst       (rst),
    .clear     (col_clear),
    .load      (col_load),
    .digit     (digit_in),
    .data      (buf_data),
    .data_next (buf_next),
    .count     (entry_cnt),
    .full      (col_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ENTRY;
      code_q       <= RESET_CODE;
      fail_cnt     <= '0;
      lock_cnt     <= '0;
      unlocked     <= 1'b0;
      locked_out   <= 1'b0;
      alarm        <= 1'b0;
      code_updated <= 1'b0;
      seven        <= SEG_L;
    end else begin
      code_updated <= 1'b0;
      case (state)
        ENTRY: begin
          if (col_full) state <= CHECK;
        end

        CHECK: begin
          if (buf_data == code_q) begin
            state    <= UNLOCKED;
            fail_cnt <= '0;
            unlocked <= 1'b1;
            seven    <= SEG_U;
          end else if (fail_cnt >= FW'(MAX_TRIES - 1)) begin
            // Saturate rather than increment past MAX_TRIES.
            state      <= LOCKOUT;
            fail_cnt   <= FW'(MAX_TRIES);
            lock_cnt   <= LW'(LOCKOUT_CYCLES);
            locked_out <= 1'b1;
            alarm      <= 1'b1;
            seven      <= SEG_DASH;
          end else begin
            state    <= ENTRY;
            fail_cnt <= fail_cnt + FW'(1);
          end
        end

        UNLOCKED: begin
          if (lock_req) begin
            state    <= ENTRY;
            unlocked <= 1'b0;
            seven    <= SEG_L;
          end else if (set_mode) begin
            state <= PROGRAM;
            seven <= SEG_P;
          end
        end

        PROGRAM: begin
          if (lock_req) begin
            state    <= ENTRY;
            unlocked <= 1'b0;
            seven    <= SEG_L;
          end else if (clear) begin
            state <= UNLOCKED;
            seven <= SEG_U;
          end else if (col_full) begin
            // buf_next already holds the final digit taken this cycle.
            code_q       <= buf_next;
            code_updated <= 1'b1;
            state        <= UNLOCKED;
            seven        <= SEG_U;
          end
        end

        LOCKOUT: begin
          // Exit on the edge where the counter shows 1, so locked_out is
          // high for exactly LOCKOUT_CYCLES cycles.
          if (lock_cnt <= LW'(1)) begin
            state      <= ENTRY;
            lock_cnt   <= '0;
            fail_cnt   <= '0;
            locked_out <= 1'b0;
            alarm      <= 1'b0;
            seven      <= SEG_L;
          end else begin
            lock_cnt <= lock_cnt - LW'(1);
          end
        end

        default: begin
          state <= ENTRY;
          seven <= SEG_L;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_lock_ctrl.sv
// Bench for digit_lock_ctrl. Status changes are predicted into exp_q by the
// driver and consumed by an independent monitor; timing-sensitive values
// (latency, lockout length, entry_cnt) are checked directly by the driver.
module tb_digit_lock_ctrl;

  localparam logic [6:0] G_L = 7'b0001110;
  localparam logic [6:0] G_U = 7'b0111110;
  localparam logic [6:0] G_P = 7'b1100111;
  localparam logic [6:0] G_D = 7'b0000001;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_in = '0;
  logic       digit_valid = 1'b0;
  logic       clear = 1'b0;
  logic       lock_req = 1'b0;
  logic       set_mode = 1'b0;
  logic       unlocked, locked_out, alarm, code_updated;
  logic [1:0] fail_cnt;
  logic [2:0] entry_cnt;
  logic [6:0] seven;

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  digit_lock_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .digit_in     (digit_in),
    .digit_valid  (digit_valid),
    .clear        (clear),
    .lock_req     (lock_req),
    .set_mode     (set_mode),
    .unlocked     (unlocked),
    .locked_out   (locked_out),
    .alarm        (alarm),
    .fail_cnt     (fail_cnt),
    .entry_cnt    (entry_cnt),
    .code_updated (code_updated),
    .seven        (seven)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [12:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic [12:0] prev_word;
  logic [12:0] mon_exp;
  wire  [12:0] cur_word = {unlocked, locked_out, alarm, code_updated, fail_cnt, seven};

  function automatic logic [12:0] st(input bit u, input bit lo, input bit al,
                                     input bit cu, input logic [1:0] fc,
                                     input logic [6:0] sg);
    return {u, lo, al, cu, fc, sg};
  endfunction

  localparam logic [12:0] W_RST = {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, G_L};

  always @(negedge clk) begin
    if (mon_en && cur_word !== prev_word) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL status_unexpected t=%0t got=%h want=none", $time, cur_word);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cur_word !== mon_exp) begin
          bad++;
          $display("FAIL status_word t=%0t got=%h want=%h", $time, cur_word, mon_exp);
        end
      end
    end
    prev_word = cur_word;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic put_digit(input logic [3:0] d);
    digit_in = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    put_digit(a);
    put_digit(b);
    put_digit(c);
    put_digit(d);
  endtask

  task automatic code_and_check(input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic [3:0] d);
    enter4(a, b, c, d);
    tick();
  endtask

  task automatic do_lock_req();
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
  endtask

  task automatic do_set_mode();
    set_mode = 1'b1;
    tick();
    set_mode = 1'b0;
  endtask

  task automatic three_wrong();
    exp_q.push_back(st(0, 0, 0, 0, 2'd1, G_L));
    code_and_check(2, 2, 2, 2);
    chk("fail_cnt_1", fail_cnt, 1);
    exp_q.push_back(st(0, 0, 0, 0, 2'd2, G_L));
    code_and_check(2, 2, 2, 2);
    chk("fail_cnt_2", fail_cnt, 2);
    exp_q.push_back(st(0, 1, 1, 0, 2'd3, G_D));
    code_and_check(2, 2, 2, 2);
    chk("fail_cnt_3", fail_cnt, 3);
    chk("lockout_entered", locked_out, 1);
    chk("alarm_on", alarm, 1);
  endtask

  // Counts edges until locked_out drops; optionally pokes every input.
  task automatic wait_lockout(output int n, input bit poke);
    n = 0;
    while (locked_out === 1'b1 && n < 2000) begin
      if (poke && n < 4) begin
        digit_in    = (n == 3) ? 4'd0 : 4'd1;
        digit_valid = 1'b1;
        clear       = (n == 1);
        lock_req    = (n == 2);
        set_mode    = (n == 3);
      end
      tick();
      digit_valid = 1'b0;
      clear = 1'b0;
      lock_req = 1'b0;
      set_mode = 1'b0;
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_unlocked", unlocked, 0);
    chk("rst_locked_out", locked_out, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_code_updated", code_updated, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_entry_cnt", entry_cnt, 0);
    chk("rst_seven", seven, G_L);
    mon_en = 1'b1;

    // Correct reset code and its latency.
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_U));
    enter4(1, 1, 1, 0);
    chk("latency_edge_k", unlocked, 0);
    tick();
    chk("latency_edge_k1", unlocked, 1);
    chk("unlock_seven", seven, G_U);
    exp_q.push_back(W_RST);
    do_lock_req();

    // Three wrong codes, full lockout.
    three_wrong();
    exp_q.push_back(W_RST);
    wait_lockout(n, 1'b0);
    chk("lockout_len", n, 1000);
    chk("post_lockout_fail", fail_cnt, 0);
    chk("post_lockout_seven", seven, G_L);

    // Lockout ignores all inputs, including the correct code.
    three_wrong();
    exp_q.push_back(W_RST);
    wait_lockout(n, 1'b1);
    chk("lockout_len_poked", n, 1000);
    chk("poked_unlocked", unlocked, 0);

    // Reprogram to 9,8,7,6.
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_U));
    code_and_check(1, 1, 1, 0);
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_P));
    do_set_mode();
    exp_q.push_back(st(1, 0, 0, 1, 2'd0, G_U));
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_U));
    enter4(9, 8, 7, 6);
    chk("code_updated_pulse", code_updated, 1);
    tick();
    exp_q.push_back(W_RST);
    do_lock_req();
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_U));
    code_and_check(9, 8, 7, 6);
    exp_q.push_back(W_RST);
    do_lock_req();
    exp_q.push_back(st(0, 0, 0, 0, 2'd1, G_L));
    code_and_check(1, 1, 1, 0);
    chk("old_code_fail", fail_cnt, 1);

    // clear beats digit_valid; then correct code clears fail_cnt.
    put_digit(9);
    put_digit(8);
    chk("entry_cnt_2", entry_cnt, 2);
    digit_in = 4'd7;
    digit_valid = 1'b1;
    clear = 1'b1;
    tick();
    digit_valid = 1'b0;
    clear = 1'b0;
    chk("clear_entry_cnt", entry_cnt, 0);
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_U));
    code_and_check(9, 8, 7, 6);

    // PROGRAM aborted by clear, then by lock_req: code unchanged.
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_P));
    do_set_mode();
    put_digit(1);
    put_digit(2);
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_U));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("prog_clear_entry_cnt", entry_cnt, 0);
    exp_q.push_back(W_RST);
    do_lock_req();
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_U));
    code_and_check(9, 8, 7, 6);
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_P));
    do_set_mode();
    put_digit(3);
    exp_q.push_back(W_RST);
    do_lock_req();
    chk("prog_lockreq_entry_cnt", entry_cnt, 0);
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_U));
    code_and_check(9, 8, 7, 6);
    exp_q.push_back(W_RST);
    do_lock_req();

    // Reset in the middle of a lockout.
    three_wrong();
    repeat (499) tick();
    chk("mid_lockout_still", locked_out, 1);
    exp_q.push_back(W_RST);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_lockout_locked_out", locked_out, 0);
    chk("rst_lockout_alarm", alarm, 0);
    chk("rst_lockout_fail", fail_cnt, 0);
    chk("rst_lockout_seven", seven, G_L);

    // Code register back to RESET_CODE; program 5,5,5,5 then reset mid-PROGRAM.
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_U));
    code_and_check(1, 1, 1, 0);
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_P));
    do_set_mode();
    exp_q.push_back(st(1, 0, 0, 1, 2'd0, G_U));
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_U));
    enter4(5, 5, 5, 5);
    tick();
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_P));
    do_set_mode();
    put_digit(4);
    put_digit(4);
    exp_q.push_back(W_RST);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_prog_entry_cnt", entry_cnt, 0);
    chk("rst_prog_unlocked", unlocked, 0);
    exp_q.push_back(st(1, 0, 0, 0, 2'd0, G_U));
    code_and_check(1, 1, 1, 0);
    exp_q.push_back(W_RST);
    do_lock_req();

    repeat (5) tick();
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
